// File: rtl/mm_req_ctrl_if.sv
// Request, response and main-memory pins of mm_req_ctrl bundled as one interface.
// master is the controller; slave is the L1 miss path plus the memory it talks to.
interface mm_req_ctrl_if;
  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [31:0]  req_addr;
  logic [31:0]  req_wb_addr;
  logic [3:0]   req_be;
  logic [255:0] req_wd;
  logic         rsp_valid;
  logic [255:0] rsp_rd;
  logic         rsp_err;
  logic [31:0]  mm_a;
  logic [3:0]   mm_be;
  logic         mm_write;
  logic         mm_read;
  logic [255:0] mm_wd;
  logic         mm_bypass;
  logic [255:0] mm_rd;
  logic         mm_valid;

  modport master (
    input  req_valid, req_op, req_addr, req_wb_addr, req_be, req_wd, mm_rd, mm_valid,
    output req_ready, rsp_valid, rsp_rd, rsp_err,
    output mm_a, mm_be, mm_write, mm_read, mm_wd, mm_bypass
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wb_addr, req_be, req_wd, mm_rd, mm_valid,
    input  req_ready, rsp_valid, rsp_rd, rsp_err,
    input  mm_a, mm_be, mm_write, mm_read, mm_wd, mm_bypass
  );
endinterface

// File: rtl/mm_req_ctrl.sv
// Main-memory request sequencer: one L1 miss-path request at a time, single-cycle
// memory strobes, one response per request with address-trap and timeout errors.
module mm_req_ctrl #(
  parameter int unsigned ADDR_BITS = 15,
  parameter int unsigned TIMEOUT   = 16
) (
  input logic           clk,
  input logic           reset,
  mm_req_ctrl_if.master bus
);

  localparam logic [2:0] OpFill   = 3'b000;
  localparam logic [2:0] OpWb     = 3'b001;
  localparam logic [2:0] OpWbFill = 3'b010;
  localparam logic [2:0] OpBypRd  = 3'b100;
  localparam logic [2:0] OpBypWr  = 3'b101;

  typedef enum logic [2:0] {StIdle, StWr, StRd, StWait, StResp} state_e;

  state_e       state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [29:0]  addr_q, addr_d;       // byte address [31:2]
  logic [26:0]  wb_addr_q, wb_addr_d; // line address [31:5]
  logic [3:0]   be_q, be_d;
  logic [255:0] wd_q, wd_d;
  logic [7:0]   cnt_q, cnt_d;

  logic         req_ready_q, req_ready_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_err_q, rsp_err_d;
  logic [255:0] rsp_rd_q, rsp_rd_d;
  logic [31:0]  mm_a_q, mm_a_d;
  logic [3:0]   mm_be_q, mm_be_d;
  logic         mm_write_q, mm_write_d;
  logic         mm_read_q, mm_read_d;
  logic [255:0] mm_wd_q, mm_wd_d;
  logic         mm_bypass_q, mm_bypass_d;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a >> ADDR_BITS) != 32'd0;
  endfunction

  // Outputs are registered, so strobes are built while entering WR/RD: from the live
  // request on accept, from the captured copy when WBFILL moves on to its read.
  logic [2:0]   cur_op;
  logic [29:0]  cur_addr;
  logic [26:0]  cur_wb_addr;
  logic [3:0]   cur_be;
  logic [255:0] cur_wd;
  logic         op_legal, addr_trap;
  logic [31:0]  wr_a, rd_a;
  logic [3:0]   wr_be;
  logic [255:0] wr_wd;
  logic         wr_byp, rd_byp;

  always_comb begin
    if (state_q == StIdle) begin
      cur_op      = bus.req_op;
      cur_addr    = bus.req_addr[31:2];
      cur_wb_addr = bus.req_wb_addr[31:5];
      cur_be      = bus.req_be;
      cur_wd      = bus.req_wd;
    end else begin
      cur_op      = op_q;
      cur_addr    = addr_q;
      cur_wb_addr = wb_addr_q;
      cur_be      = be_q;
      cur_wd      = wd_q;
    end

    op_legal  = cur_op inside {OpFill, OpWb, OpWbFill, OpBypRd, OpBypWr};
    addr_trap = ((cur_op == OpWb || cur_op == OpWbFill) && addr_bad(bus.req_wb_addr)) ||
                ((cur_op != OpWb) && addr_bad(bus.req_addr));

    wr_byp = (cur_op == OpBypWr);
    wr_a   = wr_byp ? {cur_addr, 2'b00} : {cur_wb_addr, 5'b0};
    wr_be  = wr_byp ? cur_be : 4'hF;
    wr_wd  = wr_byp ? {224'b0, cur_wd[31:0]} : cur_wd;
    rd_byp = (cur_op == OpBypRd);
    rd_a   = rd_byp ? {cur_addr, 2'b00} : {cur_addr[29:3], 5'b0};
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wb_addr_d   = wb_addr_q;
    be_d        = be_q;
    wd_d        = wd_q;
    cnt_d       = cnt_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rd_d    = rsp_rd_q;
    mm_a_d      = '0;
    mm_be_d     = '0;
    mm_write_d  = 1'b0;
    mm_read_d   = 1'b0;
    mm_wd_d     = '0;
    mm_bypass_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && req_ready_q) begin
          op_d      = bus.req_op;
          addr_d    = bus.req_addr[31:2];
          wb_addr_d = bus.req_wb_addr[31:5];
          be_d      = bus.req_be;
          wd_d      = bus.req_wd;
          if (!op_legal || addr_trap) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rd_d    = '0;
          end else if (cur_op == OpFill || cur_op == OpBypRd) begin
            state_d     = StRd;
            mm_read_d   = 1'b1;
            mm_a_d      = rd_a;
            mm_bypass_d = rd_byp;
          end else begin
            state_d     = StWr;
            mm_write_d  = 1'b1;
            mm_a_d      = wr_a;
            mm_be_d     = wr_be;
            mm_wd_d     = wr_wd;
            mm_bypass_d = wr_byp;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      StWr: begin
        if (op_q == OpWbFill) begin
          state_d     = StRd;
          mm_read_d   = 1'b1;
          mm_a_d      = rd_a;
          mm_bypass_d = rd_byp;
        end else begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rd_d    = '0;
        end
      end
      StRd: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        // Data arriving on the last allowed cycle still beats the timeout.
        if (bus.mm_valid) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rd_d    = (op_q == OpBypRd) ? {224'b0, bus.mm_rd[31:0]} : bus.mm_rd;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rd_d    = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      addr_q      <= '0;
      wb_addr_q   <= '0;
      be_q        <= '0;
      wd_q        <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= '0;
      mm_a_q      <= '0;
      mm_be_q     <= '0;
      mm_write_q  <= 1'b0;
      mm_read_q   <= 1'b0;
      mm_wd_q     <= '0;
      mm_bypass_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wb_addr_q   <= wb_addr_d;
      be_q        <= be_d;
      wd_q        <= wd_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rd_q    <= rsp_rd_d;
      mm_a_q      <= mm_a_d;
      mm_be_q     <= mm_be_d;
      mm_write_q  <= mm_write_d;
      mm_read_q   <= mm_read_d;
      mm_wd_q     <= mm_wd_d;
      mm_bypass_q <= mm_bypass_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rd    = rsp_rd_q;
  assign bus.mm_a      = mm_a_q;
  assign bus.mm_be     = mm_be_q;
  assign bus.mm_write  = mm_write_q;
  assign bus.mm_read   = mm_read_q;
  assign bus.mm_wd     = mm_wd_q;
  assign bus.mm_bypass = mm_bypass_q;

endmodule

// File: tb/tb_mm_req_ctrl.sv
// Self-checking bench for mm_req_ctrl: directed scenarios plus randomized requests
// checked against a transaction-level model of accesses, latency and response.
module tb_mm_req_ctrl;
  localparam int unsigned ADDR_BITS = 15;
  localparam int unsigned TIMEOUT   = 16;

  typedef struct {
    int           m;
    bit           wr;
    logic [31:0]  a;
    logic [3:0]   be;
    logic [255:0] wd;
    logic         byp;
  } acc_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mm_req_ctrl_if bus ();

  mm_req_ctrl #(
    .ADDR_BITS(ADDR_BITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // observations from the last transaction (m = negedge index after the accept edge)
  acc_t         obs_q[$];
  int           obs_rsp_m, obs_rsp_cnt, obs_overlap, obs_idlebus, obs_ready_in_rsp;
  logic [255:0] obs_rd;
  logic         obs_err, obs_ready_start, obs_ready_end;

  // model predictions
  acc_t         exp_q[$];
  int           exp_lat, exp_mr;
  logic [255:0] exp_rd;
  logic         exp_err;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // d: memory raises mm_valid d cycles after it samples the read (0 = never).
  task automatic predict(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wb,
                         input logic [3:0] be, input logic [255:0] wd, input logic [255:0] line,
                         input int d);
    bit   legal, line_wr, byp_wr, rd;
    int   n;
    acc_t x;
    exp_q.delete();
    exp_mr  = 0;
    exp_rd  = '0;
    exp_err = 1'b0;
    legal   = (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5);
    line_wr = (op == 3'd1 || op == 3'd2);
    byp_wr  = (op == 3'd5);
    rd      = (op == 3'd0 || op == 3'd2 || op == 3'd4);
    if (line_wr && wb >= (32'd1 << ADDR_BITS)) legal = 1'b0;
    if (op != 3'd1 && addr >= (32'd1 << ADDR_BITS)) legal = 1'b0;
    if (!legal) begin
      exp_lat = 1;
      exp_err = 1'b1;
      return;
    end
    n = 0;
    if (line_wr || byp_wr) begin
      n++;
      x.m   = n;
      x.wr  = 1'b1;
      x.a   = byp_wr ? addr - addr % 4 : wb - wb % 32;
      x.be  = byp_wr ? be : 4'hF;
      x.wd  = byp_wr ? 256'(wd[31:0]) : wd;
      x.byp = byp_wr;
      exp_q.push_back(x);
    end
    if (rd) begin
      n++;
      exp_mr = n;
      x.m    = n;
      x.wr   = 1'b0;
      x.a    = (op == 3'd4) ? addr - addr % 4 : addr - addr % 32;
      x.be   = '0;
      x.wd   = '0;
      x.byp  = (op == 3'd4);
      exp_q.push_back(x);
      if (d >= 1 && d <= int'(TIMEOUT)) begin
        exp_lat = n + d + 1;
        exp_rd  = (op == 3'd4) ? 256'(line[31:0]) : line;
      end else begin
        exp_lat = n + int'(TIMEOUT) + 1;
        exp_err = 1'b1;
      end
    end else begin
      exp_lat = n + 1;
    end
  endtask

  // Drives one request from a negedge, acts as memory, and records what the DUT does.
  // Request fields stay garbage-valid while busy; spurious mm_valid avoids the WAIT window.
  task automatic do_txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wb,
                        input logic [3:0] be, input logic [255:0] wd, input logic [255:0] line,
                        input int d, input int mr_hint, input bit spur);
    int   m;
    int   read_m;
    bit   sched, win;
    acc_t x;
    m = 0;
    read_m = 0;
    obs_q.delete();
    obs_rsp_m = 0; obs_rsp_cnt = 0; obs_overlap = 0; obs_idlebus = 0; obs_ready_in_rsp = 0;
    obs_rd = '0; obs_err = 1'b0;
    obs_ready_start = bus.req_ready;
    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.req_addr    = addr;
    bus.req_wb_addr = wb;
    bus.req_be      = be;
    bus.req_wd      = wd;
    bus.mm_valid    = 1'b0;
    while (m < 400 && !(obs_rsp_m > 0 && m == obs_rsp_m + 1)) begin
      @(negedge clk);
      m++;
      if (m == 1) begin
        bus.req_op      = 3'($urandom);
        bus.req_addr    = $urandom;
        bus.req_wb_addr = $urandom;
        bus.req_be      = 4'($urandom);
        bus.req_wd      = rand256();
      end
      if (bus.mm_write && bus.mm_read) obs_overlap++;
      if (bus.mm_write || bus.mm_read) begin
        x.m   = m;
        x.wr  = bus.mm_write;
        x.a   = bus.mm_a;
        x.be  = bus.mm_be;
        x.wd  = bus.mm_wd;
        x.byp = bus.mm_bypass;
        obs_q.push_back(x);
        if (bus.mm_read) read_m = m;
      end else if (bus.mm_a != '0 || bus.mm_be != '0 || bus.mm_wd != '0 || bus.mm_bypass) begin
        obs_idlebus++;
      end
      if (bus.rsp_valid) begin
        obs_rsp_cnt++;
        if (bus.req_ready) obs_ready_in_rsp++;
        if (obs_rsp_m == 0) begin
          obs_rsp_m = m;
          obs_rd    = bus.rsp_rd;
          obs_err   = bus.rsp_err;
        end
      end
      sched = (read_m > 0 && d > 0 && m == read_m + d);
      win   = (mr_hint > 0 && m >= mr_hint + 1 && m <= mr_hint + int'(TIMEOUT));
      bus.mm_valid = sched || (spur && !win && $urandom_range(0, 3) == 0);
      bus.mm_rd    = sched ? line : rand256();
    end
    obs_ready_end = bus.req_ready;
    bus.req_valid = 1'b0;
    bus.mm_valid  = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_vec++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
    n_vec++; if (bus.rsp_rd !== 256'b0) begin n_err++; $display("FAIL reset_rsp_rd: got %h want 0", bus.rsp_rd); end
    n_vec++; if ({bus.mm_write, bus.mm_read} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b want 00", {bus.mm_write, bus.mm_read}); end
    n_vec++; if ({bus.mm_a, bus.mm_be, bus.mm_bypass} !== 37'b0 || bus.mm_wd !== 256'b0) begin
      n_err++; $display("FAIL reset_mm_bus: got a=%h be=%h byp=%b want 0", bus.mm_a, bus.mm_be, bus.mm_bypass);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    logic [255:0] line;
    line = rand256();
    do_txn(3'b000, 32'h0000_0140, 32'h0, 4'h0, rand256(), line, 2, 1, 1'b0);
    n_vec++; if (obs_q.size() !== 1) begin n_err++; $display("FAIL fill_n_access: got %0d want 1", obs_q.size()); end
    else begin
      n_vec++; if (obs_q[0].wr || obs_q[0].a !== 32'h140 || obs_q[0].byp !== 1'b0) begin
        n_err++; $display("FAIL fill_read: got wr=%b a=%h byp=%b want wr=0 a=140 byp=0", obs_q[0].wr, obs_q[0].a, obs_q[0].byp);
      end
    end
    n_vec++; if (obs_rsp_m !== 4) begin n_err++; $display("FAIL fill_latency: got %0d want 4", obs_rsp_m); end
    n_vec++; if (obs_rd !== line) begin n_err++; $display("FAIL fill_rd: got %h want %h", obs_rd, line); end
    n_vec++; if (obs_err !== 1'b0) begin n_err++; $display("FAIL fill_err: got %b want 0", obs_err); end
  endtask

  task automatic test_wbfill();
    logic [255:0] line, wd;
    line = rand256();
    wd   = rand256();
    do_txn(3'b010, 32'h0000_1020, 32'h0000_0060, 4'h3, wd, line, 2, 2, 1'b0);
    n_vec++; if (obs_q.size() !== 2) begin n_err++; $display("FAIL wbfill_n_access: got %0d want 2", obs_q.size()); end
    else begin
      n_vec++; if (!obs_q[0].wr || obs_q[0].m !== 1 || obs_q[0].a !== 32'h60 || obs_q[0].be !== 4'hF || obs_q[0].wd !== wd) begin
        n_err++; $display("FAIL wbfill_write: got wr=%b m=%0d a=%h be=%h want wr=1 m=1 a=60 be=f", obs_q[0].wr, obs_q[0].m, obs_q[0].a, obs_q[0].be);
      end
      n_vec++; if (obs_q[1].wr || obs_q[1].m !== 2 || obs_q[1].a !== 32'h1020) begin
        n_err++; $display("FAIL wbfill_read: got wr=%b m=%0d a=%h want wr=0 m=2 a=1020", obs_q[1].wr, obs_q[1].m, obs_q[1].a);
      end
    end
    n_vec++; if (obs_rsp_m !== 5 || obs_rsp_cnt !== 1) begin n_err++; $display("FAIL wbfill_rsp: got m=%0d cnt=%0d want m=5 cnt=1", obs_rsp_m, obs_rsp_cnt); end
    n_vec++; if (obs_rd !== line || obs_err !== 1'b0) begin n_err++; $display("FAIL wbfill_data: got err=%b rd=%h want err=0 rd=%h", obs_err, obs_rd, line); end
  endtask

  task automatic test_byp_wr();
    logic [255:0] wd;
    wd = rand256();
    wd[31:0] = 32'hAABB_CCDD;
    do_txn(3'b101, 32'h0000_0107, 32'h0, 4'b0100, wd, rand256(), 2, 0, 1'b0);
    n_vec++; if (obs_q.size() !== 1) begin n_err++; $display("FAIL bypwr_n_access: got %0d want 1", obs_q.size()); end
    else begin
      n_vec++; if (!obs_q[0].wr || obs_q[0].a !== 32'h104 || obs_q[0].byp !== 1'b1 || obs_q[0].be !== 4'b0100) begin
        n_err++; $display("FAIL bypwr_access: got wr=%b a=%h byp=%b be=%b want wr=1 a=104 byp=1 be=0100", obs_q[0].wr, obs_q[0].a, obs_q[0].byp, obs_q[0].be);
      end
      n_vec++; if (obs_q[0].wd !== {224'b0, 32'hAABB_CCDD}) begin n_err++; $display("FAIL bypwr_wd: got %h want aabbccdd zero-extended", obs_q[0].wd); end
    end
    n_vec++; if (obs_rsp_m !== 2 || obs_rd !== 256'b0 || obs_err !== 1'b0) begin
      n_err++; $display("FAIL bypwr_rsp: got m=%0d err=%b rd=%h want m=2 err=0 rd=0", obs_rsp_m, obs_err, obs_rd);
    end
  endtask

  task automatic test_trap();
    logic [2:0]  op;
    logic [31:0] addr, wb;
    for (int i = 0; i < 3; i++) begin
      op   = (i == 0) ? 3'b100 : (i == 1) ? 3'b111 : 3'b001;
      addr = (i == 0) ? 32'h0001_0000 : 32'h0000_0040;
      wb   = (i == 2) ? 32'h0000_8000 : 32'h0000_0020;
      do_txn(op, addr, wb, 4'hF, rand256(), rand256(), 2, 0, 1'b0);
      n_vec++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL trap%0d_no_strobe: got %0d accesses want 0", i, obs_q.size()); end
      n_vec++; if (obs_rsp_m !== 1 || obs_err !== 1'b1 || obs_rd !== 256'b0) begin
        n_err++; $display("FAIL trap%0d_rsp: got m=%0d err=%b want m=1 err=1 rd=0", i, obs_rsp_m, obs_err);
      end
    end
  endtask

  task automatic test_timeout();
    int late_rsp, late_notready;
    late_rsp = 0;
    late_notready = 0;
    do_txn(3'b000, 32'h0000_0380, 32'h0, 4'h0, rand256(), rand256(), 0, 1, 1'b0);
    n_vec++; if (obs_rsp_m !== int'(TIMEOUT) + 2) begin n_err++; $display("FAIL timeout_latency: got %0d want %0d", obs_rsp_m, TIMEOUT + 2); end
    n_vec++; if (obs_err !== 1'b1 || obs_rd !== 256'b0) begin n_err++; $display("FAIL timeout_rsp: got err=%b rd=%h want err=1 rd=0", obs_err, obs_rd); end
    // late data after the error response must be ignored
    for (int i = 0; i < 4; i++) begin
      bus.mm_valid = 1'b1;
      bus.mm_rd    = rand256();
      @(negedge clk);
      if (bus.rsp_valid || bus.mm_read || bus.mm_write) late_rsp++;
      if (!bus.req_ready) late_notready++;
    end
    bus.mm_valid = 1'b0;
    n_vec++; if (late_rsp !== 0) begin n_err++; $display("FAIL timeout_late_valid: got %0d activity cycles want 0", late_rsp); end
    n_vec++; if (late_notready !== 0) begin n_err++; $display("FAIL timeout_late_ready: got %0d not-ready cycles want 0", late_notready); end
  endtask

  task automatic test_reset_mid();
    int           stray;
    logic [255:0] line;
    stray = 0;
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b000;
    bus.req_addr  = 32'h0000_0200;
    bus.mm_valid  = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_vec++; if ({bus.rsp_valid, bus.rsp_err, bus.mm_write, bus.mm_read, bus.mm_bypass} !== 5'b0) begin
      n_err++; $display("FAIL midreset_ctl: got %b want 00000", {bus.rsp_valid, bus.rsp_err, bus.mm_write, bus.mm_read, bus.mm_bypass});
    end
    n_vec++; if (bus.mm_a !== 32'b0 || bus.mm_be !== 4'b0 || bus.req_ready !== 1'b1) begin
      n_err++; $display("FAIL midreset_bus: got a=%h be=%h ready=%b want a=0 be=0 ready=1", bus.mm_a, bus.mm_be, bus.req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < int'(TIMEOUT) + 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.mm_read || bus.mm_write || !bus.req_ready) stray++;
    end
    n_vec++; if (stray !== 0) begin n_err++; $display("FAIL midreset_quiet: got %0d active cycles want 0", stray); end
    line = rand256();
    do_txn(3'b000, 32'h0000_0140, 32'h0, 4'h0, rand256(), line, 2, 1, 1'b0);
    n_vec++; if (obs_rsp_m !== 4 || obs_err !== 1'b0 || obs_rd !== line) begin
      n_err++; $display("FAIL midreset_fill: got m=%0d err=%b rd=%h want m=4 err=0 rd=%h", obs_rsp_m, obs_err, obs_rd, line);
    end
  endtask

  task automatic test_random(input int n);
    logic [2:0]   op;
    logic [31:0]  addr, wb;
    logic [3:0]   be;
    logic [255:0] wd, line;
    int           d, r, k;
    for (int t = 0; t < n; t++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    op = 3'b000;
        2:       op = 3'b001;
        3, 4:    op = 3'b010;
        5:       op = 3'b100;
        6, 7:    op = 3'b101;
        8:       op = ($urandom_range(0, 1) == 0) ? 3'b011 : 3'b110;
        default: op = 3'($urandom);
      endcase
      addr = $urandom & 32'h0000_7FFF;
      wb   = $urandom & 32'h0000_7FFF;
      if ($urandom_range(0, 9) == 0) addr = addr | (32'd1 << $urandom_range(15, 31));
      if ($urandom_range(0, 9) == 0) wb = wb | (32'd1 << $urandom_range(15, 31));
      be   = 4'($urandom);
      wd   = rand256();
      line = rand256();
      r = $urandom_range(0, 9);
      if (r < 8)       d = $urandom_range(1, 4);
      else if (r == 8) d = $urandom_range(5, TIMEOUT);
      else             d = ($urandom_range(0, 1) == 0) ? 0 : int'(TIMEOUT) + 1;
      predict(op, addr, wb, be, wd, line, d);
      do_txn(op, addr, wb, be, wd, line, d, exp_mr, 1'b1);
      n_vec++; if (obs_ready_start !== 1'b1) begin n_err++; $display("FAIL rnd%0d_ready_start: got %b want 1", t, obs_ready_start); end
      n_vec++; if (obs_q.size() !== exp_q.size()) begin
        n_err++; $display("FAIL rnd%0d_n_access: got %0d want %0d (op=%b)", t, obs_q.size(), exp_q.size(), op);
      end
      k = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < k; i++) begin
        n_vec++; if (obs_q[i].m !== exp_q[i].m || obs_q[i].wr !== exp_q[i].wr || obs_q[i].a !== exp_q[i].a || obs_q[i].byp !== exp_q[i].byp) begin
          n_err++; $display("FAIL rnd%0d_access%0d: got m=%0d wr=%b a=%h byp=%b want m=%0d wr=%b a=%h byp=%b", t, i,
                            obs_q[i].m, obs_q[i].wr, obs_q[i].a, obs_q[i].byp, exp_q[i].m, exp_q[i].wr, exp_q[i].a, exp_q[i].byp);
        end
        if (exp_q[i].wr) begin
          n_vec++; if (obs_q[i].be !== exp_q[i].be || obs_q[i].wd !== exp_q[i].wd) begin
            n_err++; $display("FAIL rnd%0d_wdata%0d: got be=%h wd=%h want be=%h wd=%h", t, i, obs_q[i].be, obs_q[i].wd, exp_q[i].be, exp_q[i].wd);
          end
        end
      end
      n_vec++; if (obs_rsp_m !== exp_lat || obs_rsp_cnt !== 1) begin
        n_err++; $display("FAIL rnd%0d_latency: got m=%0d cnt=%0d want m=%0d cnt=1 (op=%b d=%0d)", t, obs_rsp_m, obs_rsp_cnt, exp_lat, op, d);
      end
      n_vec++; if (obs_err !== exp_err) begin n_err++; $display("FAIL rnd%0d_err: got %b want %b (op=%b)", t, obs_err, exp_err, op); end
      n_vec++; if (obs_rd !== exp_rd) begin n_err++; $display("FAIL rnd%0d_rd: got %h want %h", t, obs_rd, exp_rd); end
      n_vec++; if (obs_overlap !== 0 || obs_idlebus !== 0) begin
        n_err++; $display("FAIL rnd%0d_bus_hygiene: got overlap=%0d idle_nonzero=%0d want 0 0", t, obs_overlap, obs_idlebus);
      end
      n_vec++; if (obs_ready_in_rsp !== 0 || obs_ready_end !== 1'b1) begin
        n_err++; $display("FAIL rnd%0d_ready: got in_rsp=%0d end=%b want 0 1", t, obs_ready_in_rsp, obs_ready_end);
      end
    end
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_op      = '0;
    bus.req_addr    = '0;
    bus.req_wb_addr = '0;
    bus.req_be      = '0;
    bus.req_wd      = '0;
    bus.mm_rd       = '0;
    bus.mm_valid    = 1'b0;
    test_reset();
    test_fill();
    test_wbfill();
    test_byp_wr();
    test_trap();
    test_timeout();
    test_reset_mid();
    test_random(200);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mm_req_ctrl.md
Name: mm_req_ctrl

Overview:
- Request sequencer directly upstream of the banked main memory; the only master that drives its a/be/write/read/wd/bypass pins.
- Accepts one L1 miss-path request at a time: line fill, dirty-line writeback, combined writeback+fill, bypass word read, bypass byte/word write.
- Issues single-cycle memory strobes, waits for memory valid, and returns one response per request with address-trap and timeout error reporting.

Parameters:
- ADDR_BITS, 15, implemented byte-address width; req address bits [31:ADDR_BITS] must be zero.
- TIMEOUT, 16, max cycles in WAIT for mm_valid before error response (range 2..255).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_op  in  3  000 FILL, 001 WB, 010 WBFILL, 100 BYP_RD, 101 BYP_WR; others illegal
- req_addr  in  32  byte address (fill / bypass target)
- req_wb_addr  in  32  victim line address (WB, WBFILL)
- req_be  in  4  byte enables (BYP_WR only)
- req_wd  in  256  write line; bypass write data in [31:0]
- rsp_valid  out  1  one-cycle response pulse
- rsp_rd  out  256  read data (FILL, WBFILL full line; BYP_RD word in [31:0], upper zero)
- rsp_err  out  1  qualified by rsp_valid: trap, illegal op, or timeout
- mm_a  out  32  memory address
- mm_be  out  4  memory byte enables
- mm_write  out  1  memory write strobe
- mm_read  out  1  memory read strobe
- mm_wd  out  256  memory write data
- mm_bypass  out  1  bypass mode select
- mm_rd  in  256  memory read data
- mm_valid  in  1  memory read data valid

Behaviour:
- Reset (async): state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rd=0; all mm_* outputs 0; timeout counter 0.
- All outputs registered. req_ready=1 only in IDLE and not while rsp_valid is high. On accept, op/addr/wb_addr/be/wd are captured; inputs are ignored until the next IDLE.
- States: IDLE, WR, RD, WAIT, RESP.
- IDLE on accept: illegal op, or any checked address with bits [31:ADDR_BITS] nonzero (req_wb_addr for WB/WBFILL, req_addr for FILL/WBFILL/BYP_*) -> RESP with err=1; no mm strobe ever issued. Else WB/WBFILL/BYP_WR -> WR; FILL/BYP_RD -> RD.
- WR (1 cycle): mm_write=1. Line op: mm_a={wb_addr[31:5],5'b0}, mm_be=4'hF, mm_bypass=0, mm_wd=wd. BYP_WR: mm_a={addr[31:2],2'b0}, mm_be=be, mm_bypass=1, mm_wd={224'b0,wd[31:0]}. Next: WBFILL -> RD; others -> RESP.
- RD (1 cycle): mm_read=1, mm_a={addr[31:5],5'b0} (line, mm_bypass=0) or {addr[31:2],2'b0} (BYP_RD, mm_bypass=1). Next WAIT, counter cleared.
- WAIT: counter increments each cycle. mm_valid=1 -> capture mm_rd (BYP_RD: mm_rd[31:0] zero-extended) into rsp_rd, -> RESP, err=0. mm_valid with counter at TIMEOUT-1 on same cycle: data wins. Counter reaching TIMEOUT without valid -> RESP, err=1, rsp_rd=0.
- mm_valid outside WAIT is ignored.
- RESP: rsp_valid=1 for exactly one cycle; rsp_rd=0 for WB/BYP_WR; -> IDLE. Next request accepted the cycle after rsp_valid.
- Strobes never overlap: mm_write and mm_read never both 1; each asserted exactly one cycle per access; mm_* return to 0 outside WR/RD.
- Latency with memory valid one cycle after read: FILL/BYP_RD accept->rsp_valid 4 cycles; WB/BYP_WR 2; WBFILL 5; trap/illegal 1.
- Reset mid-operation: immediate abort to IDLE, strobes drop, no response produced.

Test Plan:
- FILL addr 0x0000_0140, memory returns line L one cycle after read -> one mm_read at mm_a=0x140, mm_bypass=0, rsp_valid 4 cycles after accept, rsp_rd=L, rsp_err=0.
- WBFILL wb_addr 0x0000_0060, addr 0x0000_1020 -> mm_write at 0x60 be=F wd=req_wd, next cycle mm_read at 0x1020, one response with filled line, err=0.
- BYP_WR addr 0x0000_0107 be=4'b0100 wd[31:0]=0xAABBCCDD -> mm_a=0x104, mm_bypass=1, mm_be=4'b0100, mm_wd[31:0]=0xAABBCCDD, upper zero; rsp_rd=0.
- BYP_RD addr 0x0001_0000 (ADDR_BITS=15) -> no mm strobe, rsp_valid next cycle, rsp_err=1; req_op=3'b111 -> same.
- FILL with mm_valid held 0 -> rsp_valid TIMEOUT cycles after entering WAIT, rsp_err=1, rsp_rd=0; late mm_valid afterwards ignored.
- Assert reset during WAIT -> all outputs 0 that cycle, no rsp_valid; following FILL completes normally.
